// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_pkg
// Purpose  : Opcode/funct constants, state encodings, ALU ops and mux selects
//            shared by the multi-cycle MIPS control unit.
// Revision : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

   typedef logic [3:0] state_t;

   localparam state_t S_FETCH    = 4'd0;
   localparam state_t S_DECODE   = 4'd1;
   localparam state_t S_EXEC_R   = 4'd2;
   localparam state_t S_WB_R     = 4'd3;
   localparam state_t S_EXEC_I   = 4'd4;
   localparam state_t S_WB_I     = 4'd5;
   localparam state_t S_EXEC_MEM = 4'd6;
   localparam state_t S_MEM      = 4'd7;
   localparam state_t S_WB_LW    = 4'd8;
   localparam state_t S_EXEC_BR  = 4'd9;
   localparam state_t S_JUMP     = 4'd10;
   localparam state_t S_JUMP_R   = 4'd11;
   localparam state_t S_JAL_WB   = 4'd12;

   localparam logic [5:0] c_op_rtype = 6'b000000;
   localparam logic [5:0] c_op_j     = 6'b000010;
   localparam logic [5:0] c_op_jal   = 6'b000011;
   localparam logic [5:0] c_op_beq   = 6'b000100;
   localparam logic [5:0] c_op_bne   = 6'b000101;
   localparam logic [5:0] c_op_addi  = 6'b001000;
   localparam logic [5:0] c_op_xori  = 6'b001110;
   localparam logic [5:0] c_op_lw    = 6'b100011;
   localparam logic [5:0] c_op_sw    = 6'b101011;

   localparam logic [5:0] c_fn_add = 6'b100000;
   localparam logic [5:0] c_fn_sub = 6'b100010;
   localparam logic [5:0] c_fn_slt = 6'b101010;
   localparam logic [5:0] c_fn_xor = 6'b100110;
   localparam logic [5:0] c_fn_jr  = 6'b001000;

   localparam logic [2:0] c_alu_add = 3'd0;
   localparam logic [2:0] c_alu_sub = 3'd1;
   localparam logic [2:0] c_alu_slt = 3'd2;
   localparam logic [2:0] c_alu_xor = 3'd3;

   localparam logic [1:0] c_srcb_rt    = 2'd0;
   localparam logic [1:0] c_srcb_four  = 2'd1;
   localparam logic [1:0] c_srcb_imm   = 2'd2;
   localparam logic [1:0] c_srcb_immx4 = 2'd3;

   localparam logic [1:0] c_dst_rt  = 2'd0;
   localparam logic [1:0] c_dst_rd  = 2'd1;
   localparam logic [1:0] c_dst_r31 = 2'd2;

   localparam logic [1:0] c_m2r_alu = 2'd0;
   localparam logic [1:0] c_m2r_mem = 2'd1;
   localparam logic [1:0] c_m2r_pc4 = 2'd2;

   localparam logic [1:0] c_pc_alu    = 2'd0;
   localparam logic [1:0] c_pc_branch = 2'd1;
   localparam logic [1:0] c_pc_jump   = 2'd2;
   localparam logic [1:0] c_pc_rs     = 2'd3;

   // DECODE dispatch target; S_FETCH doubles as the "unsupported" marker.
   function automatic state_t dispatch_state(input logic [5:0] opcode, input logic [5:0] funct);
      state_t v;
      v = S_FETCH;
      case (opcode)
         c_op_rtype: begin
            case (funct)
               c_fn_add, c_fn_sub, c_fn_slt, c_fn_xor: v = S_EXEC_R;
               c_fn_jr:                                v = S_JUMP_R;
               default:                                v = S_FETCH;
            endcase
         end
         c_op_lw, c_op_sw:     v = S_EXEC_MEM;
         c_op_beq, c_op_bne:   v = S_EXEC_BR;
         c_op_addi, c_op_xori: v = S_EXEC_I;
         c_op_j:               v = S_JUMP;
         c_op_jal:             v = S_JAL_WB;
         default:              v = S_FETCH;
      endcase
      return v;
   endfunction

   function automatic logic [2:0] funct_alu_op(input logic [5:0] funct);
      logic [2:0] v;
      case (funct)
         c_fn_sub: v = c_alu_sub;
         c_fn_slt: v = c_alu_slt;
         c_fn_xor: v = c_alu_xor;
         default:  v = c_alu_add;
      endcase
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/control_output_decode.sv
`default_nettype none
// ============================================================================
// Module   : control_output_decode
// Purpose  : Combinational decode of FSM state (plus opcode/funct/alu_zero)
//            into datapath control signals.
// Revision : 1.0 - initial release
// ============================================================================
module control_output_decode
   import mips_ctrl_pkg::*;
#(
   parameter int ALUOP_W = 3
) (
   input  logic [3:0]         state,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               alu_zero,
   input  logic               mem_ready,
   output logic               ir_we,
   output logic               pc_we,
   output logic               reg_we,
   output logic               mem_re,
   output logic               mem_we,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [ALUOP_W-1:0] alu_op,
   output logic [1:0]         reg_dst,
   output logic [1:0]         mem_to_reg,
   output logic [1:0]         pc_src,
   output logic               illegal
);

   logic [2:0] w_op;

   assign alu_op = ALUOP_W'(w_op);

   always_comb begin
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      reg_we     = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = c_srcb_rt;
      w_op       = c_alu_add;
      reg_dst    = c_dst_rt;
      mem_to_reg = c_m2r_alu;
      pc_src     = c_pc_alu;
      illegal    = 1'b0;
      case (state)
         S_FETCH: begin
            mem_re    = 1'b1;
            alu_src_b = c_srcb_four;
            ir_we     = mem_ready;
            pc_we     = mem_ready;
         end
         S_DECODE: begin
            alu_src_b = c_srcb_immx4;
            illegal   = (dispatch_state(opcode, funct) == S_FETCH);
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            w_op      = funct_alu_op(funct);
         end
         S_WB_R: begin
            reg_we  = 1'b1;
            reg_dst = c_dst_rd;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = c_srcb_imm;
            w_op      = (opcode == c_op_xori) ? c_alu_xor : c_alu_add;
         end
         S_WB_I: begin
            reg_we = 1'b1;
         end
         S_EXEC_MEM: begin
            alu_src_a = 1'b1;
            alu_src_b = c_srcb_imm;
         end
         S_MEM: begin
            mem_re = (opcode == c_op_lw);
            mem_we = (opcode != c_op_lw);
         end
         S_WB_LW: begin
            reg_we     = 1'b1;
            mem_to_reg = c_m2r_mem;
         end
         S_EXEC_BR: begin
            alu_src_a = 1'b1;
            w_op      = c_alu_sub;
            pc_src    = c_pc_branch;
            pc_we     = (opcode == c_op_bne) ? ~alu_zero : alu_zero;
         end
         S_JUMP: begin
            pc_we  = 1'b1;
            pc_src = c_pc_jump;
         end
         S_JUMP_R: begin
            pc_we  = 1'b1;
            pc_src = c_pc_rs;
         end
         S_JAL_WB: begin
            reg_we     = 1'b1;
            reg_dst    = c_dst_r31;
            mem_to_reg = c_m2r_pc4;
            pc_we      = 1'b1;
            pc_src     = c_pc_jump;
         end
         default: begin
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_fsm
// Purpose  : Multi-cycle MIPS control unit: state register, next-state logic
//            and reset gating of the decoded control outputs.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm
   import mips_ctrl_pkg::*;
#(
   parameter int STATE_W = 4,
   parameter int ALUOP_W = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               alu_zero,
   input  logic               mem_ready,
   output logic               ir_we,
   output logic               pc_we,
   output logic               reg_we,
   output logic               mem_re,
   output logic               mem_we,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [ALUOP_W-1:0] alu_op,
   output logic [1:0]         reg_dst,
   output logic [1:0]         mem_to_reg,
   output logic [1:0]         pc_src,
   output logic               illegal,
   output logic [STATE_W-1:0] state_out
);

   state_t r_state;
   state_t w_next;

   logic               w_ir_we, w_pc_we, w_reg_we, w_mem_re, w_mem_we, w_illegal;
   logic               w_alu_src_a;
   logic [1:0]         w_alu_src_b, w_reg_dst, w_mem_to_reg, w_pc_src;
   logic [ALUOP_W-1:0] w_alu_op;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:   w_next = dispatch_state(opcode, funct);
         S_EXEC_R:   w_next = S_WB_R;
         S_EXEC_I:   w_next = S_WB_I;
         S_EXEC_MEM: w_next = S_MEM;
         S_MEM: begin
            if (!mem_ready)            w_next = S_MEM;
            else if (opcode == c_op_lw) w_next = S_WB_LW;
            else                       w_next = S_FETCH;
         end
         default:    w_next = S_FETCH;
      endcase
   end

   control_output_decode #(
      .ALUOP_W (ALUOP_W)
   ) u_decode (
      .state      (r_state),
      .opcode     (opcode),
      .funct      (funct),
      .alu_zero   (alu_zero),
      .mem_ready  (mem_ready),
      .ir_we      (w_ir_we),
      .pc_we      (w_pc_we),
      .reg_we     (w_reg_we),
      .mem_re     (w_mem_re),
      .mem_we     (w_mem_we),
      .alu_src_a  (w_alu_src_a),
      .alu_src_b  (w_alu_src_b),
      .alu_op     (w_alu_op),
      .reg_dst    (w_reg_dst),
      .mem_to_reg (w_mem_to_reg),
      .pc_src     (w_pc_src),
      .illegal    (w_illegal)
   );

   // State already reads FETCH during reset, but FETCH's own decode must not leak out.
   assign ir_we      = w_ir_we   & ~reset;
   assign pc_we      = w_pc_we   & ~reset;
   assign reg_we     = w_reg_we  & ~reset;
   assign mem_re     = w_mem_re  & ~reset;
   assign mem_we     = w_mem_we  & ~reset;
   assign illegal    = w_illegal & ~reset;
   assign alu_src_a  = w_alu_src_a & ~reset;
   assign alu_src_b  = reset ? 2'd0 : w_alu_src_b;
   assign alu_op     = reset ? '0 : w_alu_op;
   assign reg_dst    = reset ? 2'd0 : w_reg_dst;
   assign mem_to_reg = reset ? 2'd0 : w_mem_to_reg;
   assign pc_src     = reset ? 2'd0 : w_pc_src;
   assign state_out  = STATE_W'(r_state);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_fsm
// Purpose  : Directed scoreboard bench for the multi-cycle control unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;

   typedef struct packed {
      logic [3:0] st;
      logic       ir_we, pc_we, reg_we, mem_re, mem_we, ill;
      logic       a;
      logic [1:0] b;
      logic [2:0] op;
      logic [1:0] dst, m2r, psrc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       alu_zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       ir_we, pc_we, reg_we, mem_re, mem_we, alu_src_a, illegal;
   logic [1:0] alu_src_b, reg_dst, mem_to_reg, pc_src;
   logic [2:0] alu_op;
   logic [3:0] state_out;

   exp_t act;
   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   multicycle_control_fsm #(.STATE_W(4), .ALUOP_W(3)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
      .alu_zero(alu_zero), .mem_ready(mem_ready),
      .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .pc_src(pc_src),
      .illegal(illegal), .state_out(state_out)
   );

   always #5 clk = ~clk;

   assign act = '{state_out, ir_we, pc_we, reg_we, mem_re, mem_we, illegal,
                  alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, pc_src};

   // w = {ir_we, pc_we, reg_we, mem_re, mem_we, illegal}
   function automatic exp_t mk(input logic [3:0] st, input logic [5:0] w, input logic a,
                               input logic [1:0] b, input logic [2:0] op,
                               input logic [1:0] dst, input logic [1:0] m2r,
                               input logic [1:0] psrc);
      return '{st, w[5], w[4], w[3], w[2], w[1], w[0], a, b, op, dst, m2r, psrc};
   endfunction

   // One clock cycle: drive inputs, queue the expectation, compare at negedge.
   task automatic step(input string tag, input logic rst, input logic rdy,
                       input logic z, input exp_t e);
      exp_t exp_v;
      reset     = rst;
      mem_ready = rdy;
      alu_zero  = z;
      sb_q.push_back(e);
      @(negedge clk);
      exp_v = sb_q.pop_front();
      checks++;
      assert (act === exp_v)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, act, exp_v);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input logic [5:0] op, input logic [5:0] fn);
      opcode = op;
      funct  = fn;
   endtask

   initial begin
      exp_t z0, f_rdy, f_wait, dec;
      z0     = mk(4'd0, 6'b000000, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0);
      f_rdy  = mk(4'd0, 6'b110100, 0, 2'd1, 3'd0, 2'd0, 2'd0, 2'd0);
      f_wait = mk(4'd0, 6'b000100, 0, 2'd1, 3'd0, 2'd0, 2'd0, 2'd0);
      dec    = mk(4'd1, 6'b000000, 0, 2'd3, 3'd0, 2'd0, 2'd0, 2'd0);

      @(posedge clk);
      #1;
      step("reset_hold", 1, 1, 0, z0);

      // ADD: 4 cycles
      instr(6'h00, 6'h20);
      step("add_fetch", 0, 1, 0, f_rdy);
      step("add_decode", 0, 1, 0, dec);
      step("add_exec", 0, 1, 0, mk(4'd2, 6'b000000, 1, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0));
      step("add_wb", 0, 1, 0, mk(4'd3, 6'b001000, 0, 2'd0, 3'd0, 2'd1, 2'd0, 2'd0));

      // SUB and SLT exercise funct-driven alu_op
      instr(6'h00, 6'h22);
      step("sub_fetch", 0, 1, 0, f_rdy);
      step("sub_decode", 0, 1, 0, dec);
      step("sub_exec", 0, 1, 0, mk(4'd2, 6'b000000, 1, 2'd0, 3'd1, 2'd0, 2'd0, 2'd0));
      step("sub_wb", 0, 1, 0, mk(4'd3, 6'b001000, 0, 2'd0, 3'd0, 2'd1, 2'd0, 2'd0));
      instr(6'h00, 6'h2A);
      step("slt_fetch", 0, 1, 0, f_rdy);
      step("slt_decode", 0, 1, 0, dec);
      step("slt_exec", 0, 1, 0, mk(4'd2, 6'b000000, 1, 2'd0, 3'd2, 2'd0, 2'd0, 2'd0));
      step("slt_wb", 0, 1, 0, mk(4'd3, 6'b001000, 0, 2'd0, 3'd0, 2'd1, 2'd0, 2'd0));

      // LW with three wait cycles in MEM: 8 cycles total
      instr(6'h23, 6'h3F);
      step("lw_fetch", 0, 1, 0, f_rdy);
      step("lw_decode", 0, 1, 0, dec);
      step("lw_exec", 0, 1, 0, mk(4'd6, 6'b000000, 1, 2'd2, 3'd0, 2'd0, 2'd0, 2'd0));
      for (int i = 0; i < 3; i++)
         step("lw_mem_wait", 0, 0, 0, mk(4'd7, 6'b000100, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0));
      step("lw_mem_done", 0, 1, 0, mk(4'd7, 6'b000100, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0));
      step("lw_wb", 0, 1, 0, mk(4'd8, 6'b001000, 0, 2'd0, 3'd0, 2'd0, 2'd1, 2'd0));

      // SW after a stalled fetch: no IR/PC write until mem_ready
      instr(6'h2B, 6'h00);
      step("sw_fetch_wait0", 0, 0, 0, f_wait);
      step("sw_fetch_wait1", 0, 0, 0, f_wait);
      step("sw_fetch", 0, 1, 0, f_rdy);
      step("sw_decode", 0, 1, 0, dec);
      step("sw_exec", 0, 1, 0, mk(4'd6, 6'b000000, 1, 2'd2, 3'd0, 2'd0, 2'd0, 2'd0));
      step("sw_mem", 0, 1, 0, mk(4'd7, 6'b000010, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0));

      // Branches with alu_zero=1
      instr(6'h04, 6'h00);
      step("beq_fetch", 0, 1, 1, f_rdy);
      step("beq_decode", 0, 1, 1, dec);
      step("beq_exec", 0, 1, 1, mk(4'd9, 6'b010000, 1, 2'd0, 3'd1, 2'd0, 2'd0, 2'd1));
      instr(6'h05, 6'h00);
      step("bne_fetch", 0, 1, 1, f_rdy);
      step("bne_decode", 0, 1, 1, dec);
      step("bne_exec", 0, 1, 1, mk(4'd9, 6'b000000, 1, 2'd0, 3'd1, 2'd0, 2'd0, 2'd1));

      // JAL, J, JR: 3 cycles each
      instr(6'h03, 6'h00);
      step("jal_fetch", 0, 1, 0, f_rdy);
      step("jal_decode", 0, 1, 0, dec);
      step("jal_wb", 0, 1, 0, mk(4'd12, 6'b011000, 0, 2'd0, 3'd0, 2'd2, 2'd2, 2'd2));
      instr(6'h02, 6'h00);
      step("j_fetch", 0, 1, 0, f_rdy);
      step("j_decode", 0, 1, 0, dec);
      step("j_jump", 0, 1, 0, mk(4'd10, 6'b010000, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd2));
      instr(6'h00, 6'h08);
      step("jr_fetch", 0, 1, 0, f_rdy);
      step("jr_decode", 0, 1, 0, dec);
      step("jr_jump", 0, 1, 0, mk(4'd11, 6'b010000, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd3));

      // XORI
      instr(6'h0E, 6'h00);
      step("xori_fetch", 0, 1, 0, f_rdy);
      step("xori_decode", 0, 1, 0, dec);
      step("xori_exec", 0, 1, 0, mk(4'd4, 6'b000000, 1, 2'd2, 3'd3, 2'd0, 2'd0, 2'd0));
      step("xori_wb", 0, 1, 0, mk(4'd5, 6'b001000, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0));

      // Unsupported opcode and unsupported R-type funct
      instr(6'h3F, 6'h00);
      step("illop_fetch", 0, 1, 0, f_rdy);
      step("illop_decode", 0, 1, 0, mk(4'd1, 6'b000001, 0, 2'd3, 3'd0, 2'd0, 2'd0, 2'd0));
      instr(6'h00, 6'h3F);
      step("illfn_fetch", 0, 1, 0, f_rdy);
      step("illfn_decode", 0, 1, 0, mk(4'd1, 6'b000001, 0, 2'd3, 3'd0, 2'd0, 2'd0, 2'd0));

      // Reset in the middle of LW's MEM wait: FETCH at once, WB_LW never reached
      instr(6'h23, 6'h00);
      step("rlw_fetch", 0, 1, 0, f_rdy);
      step("rlw_decode", 0, 1, 0, dec);
      step("rlw_exec", 0, 1, 0, mk(4'd6, 6'b000000, 1, 2'd2, 3'd0, 2'd0, 2'd0, 2'd0));
      step("rlw_mem", 0, 0, 0, mk(4'd7, 6'b000100, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0));
      step("rlw_reset_async", 1, 1, 0, z0);
      step("rlw_reset_hold", 1, 1, 0, z0);
      step("rlw_after_reset", 0, 0, 0, f_wait);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
